// File: rtl/mult_seq_ctrl_if.sv
// Control bus between the multiplier sequencer and its surroundings:
// tick/request inputs in, datapath strobes and status out.
interface mult_seq_ctrl_if #(
  parameter int CW = 3
);
  logic          en;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          clr;
  logic          ld;
  logic [1:0]    sel;
  logic [CW-1:0] bsel;

  modport master (
    output en, start, abort,
    input  busy, done, clr, ld, sel, bsel
  );

  modport slave (
    input  en, start, abort,
    output busy, done, clr, ld, sel, bsel
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier: edge-detected start, en-gated stepping
// through CLEAR/LOAD/SHIFT*N/DONE, with abort and back-to-back runs.
module mult_seq_ctrl #(
  parameter int N  = 6,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  mult_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pend, pend_nx;
  logic          start_q;
  logic          rise, go, cancel;

  assign rise   = bus.start & ~start_q;
  assign go     = bus.en & ~bus.abort;
  assign cancel = bus.en & bus.abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend    <= pend_nx;
      start_q <= bus.start;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.clr  = 1'b0;
    bus.ld   = 1'b0;
    bus.sel  = 2'b00;
    bus.bsel = '0;

    // Requests are only latched when idle/done; consumption below takes precedence.
    if (rise && !bus.abort && (state == IDLE || state == DONE)) pend_nx = 1'b1;
    if (state == DONE && bus.abort) pend_nx = 1'b0;

    case (state)
      IDLE: begin
        if (bus.en && pend) begin
          state_nx = CLEAR;
          pend_nx  = 1'b0;
        end
      end
      CLEAR: begin
        bus.busy = 1'b1;
        bus.clr  = go;
        if (go) state_nx = LOAD;
      end
      LOAD: begin
        bus.busy = 1'b1;
        bus.sel  = go ? 2'b01 : 2'b00;
        if (go) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
        end
      end
      SHIFT: begin
        bus.busy = 1'b1;
        bus.bsel = cnt;
        bus.ld   = go;
        bus.sel  = go ? 2'b10 : 2'b00;
        if (go) begin
          if (cnt == LAST) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.en) begin
          if (pend && !bus.abort) begin
            state_nx = CLEAR;
            pend_nx  = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        if (bus.en) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
    endcase

    // Abort on a tick in any busy state cancels the run and any pending request.
    if (cancel && (state == CLEAR || state == LOAD || state == SHIFT)) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      pend_nx  = 1'b0;
    end
  end

endmodule
